// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_stage_if;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic [31:0] imemRdata;
  logic        imemReady;

  modport master (
    output imemAddr,
    output imemReq,
    input  imemRdata,
    input  imemReady
  );

  modport slave (
    input  imemAddr,
    input  imemReq,
    output imemRdata,
    output imemReady
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, instruction-memory handshake and IF/ID pipeline register.
// Optional macro FETCH_PERF_EN adds saturating stall/bubble cycle counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCWrite,
  input  logic                  IfIdWrite,
  input  logic                  flush,
  input  logic [31:0]           redirectPC,
  if_fetch_stage_if.master      imem,
  output logic [31:0]           IfIdInst,
  output logic [31:0]           IfIdPC4,
`ifdef FETCH_PERF_EN
  output logic [31:0]           stallCycles,
  output logic [31:0]           bubbleCycles,
`endif
  output logic                  IfIdValid
);

  typedef enum logic [1:0] {FETCH, HOLD, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;

  logic        stall;
  logic        flush_eff;
  logic        load_bubble;
  logic [31:0] pc_plus4;

  // A half-asserted hazard request still means ID is holding its instruction.
  assign stall     = ~PCWrite | ~IfIdWrite;
  assign flush_eff = flush & ~stall;
  assign pc_plus4  = pc_q + 32'd4;

  assign imem.imemAddr = pc_q;
  assign imem.imemReq  = (state_q == FETCH) & rst;

  assign IfIdInst  = inst_q;
  assign IfIdPC4   = pc4_q;
  assign IfIdValid = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_d       = buf_q;
    load_bubble = 1'b0;

    case (state_q)
      FETCH: begin
        if (flush_eff) begin
          pc_d        = redirectPC;
          load_bubble = 1'b1;
          state_d     = REDIR;
        end else if (imem.imemReady && !stall) begin
          inst_d  = imem.imemRdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else if (imem.imemReady) begin
          // Word arrived while ID is frozen: park it so it is not re-fetched.
          buf_d   = imem.imemRdata;
          state_d = HOLD;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (stall) begin
          state_d = HOLD;
        end else if (flush_eff) begin
          pc_d        = redirectPC;
          buf_d       = 32'd0;
          load_bubble = 1'b1;
          state_d     = REDIR;
        end else begin
          inst_d  = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      REDIR: begin
        if (flush_eff) begin
          pc_d        = redirectPC;
          load_bubble = 1'b1;
        end else begin
          load_bubble = ~stall;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (load_bubble) begin
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stallCycles  = stall_cnt_q;
  assign bubbleCycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage with a zero-wait memory model
// whose ready line is controlled per vector.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        ifid_write;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        ready_r;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
`endif

  int errors = 0;
  int checks = 0;

  if_fetch_stage_if mif ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PCWrite     (pc_write),
    .IfIdWrite   (ifid_write),
    .flush       (flush),
    .redirectPC  (redirect_pc),
    .imem        (mif.master),
    .IfIdInst    (ifid_inst),
    .IfIdPC4     (ifid_pc4),
`ifdef FETCH_PERF_EN
    .stallCycles (stall_cycles),
    .bubbleCycles(bubble_cycles),
`endif
    .IfIdValid   (ifid_valid)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  assign mif.imemReady = ready_r;
  assign mif.imemRdata = ready_r ? memw(mif.imemAddr) : 32'hDEAD_DEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_req;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  function automatic vec_t mk(input logic pw, input logic iw, input logic fl,
                              input logic [31:0] rpc, input logic rdy,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic ev, input logic [31:0] ea, input logic er);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.rpc = rpc; v.rdy = rdy;
    v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_addr = ea; v.e_req = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl,
                       input logic [31:0] rpc, input logic rdy);
    pc_write = pw; ifid_write = iw; flush = fl; redirect_pc = rpc; ready_r = rdy;
  endtask

  task automatic check_out(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev, input logic [31:0] ea, input logic er);
    chk({tag, ".inst"},  ifid_inst, ei);
    chk({tag, ".pc4"},   ifid_pc4, ep);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, ev});
    chk({tag, ".addr"},  mif.imemAddr, ea);
    chk({tag, ".req"},   {31'd0, mif.imemReq}, {31'd0, er});
    $display("%s: inst=%08h pc4=%08h valid=%0b addr=%08h req=%0b",
             tag, ifid_inst, ifid_pc4, ifid_valid, mif.imemAddr, mif.imemReq);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Zero-wait sequential fetch from reset.
    vt[0]  = mk(1,1,0,0,1, memw(32'h00), 32'h04, 1, 32'h04, 1);
    vt[1]  = mk(1,1,0,0,1, memw(32'h04), 32'h08, 1, 32'h08, 1);
    vt[2]  = mk(1,1,0,0,1, memw(32'h08), 32'h0C, 1, 32'h0C, 1);
    vt[3]  = mk(1,1,0,0,1, memw(32'h0C), 32'h10, 1, 32'h10, 1);
    // Ready with stall at 0x10: HOLD for two cycles, then release.
    vt[4]  = mk(0,0,0,0,1, memw(32'h0C), 32'h10, 1, 32'h10, 0);
    vt[5]  = mk(0,0,0,0,1, memw(32'h0C), 32'h10, 1, 32'h10, 0);
    vt[6]  = mk(1,1,0,0,1, memw(32'h10), 32'h14, 1, 32'h14, 1);
    vt[7]  = mk(1,1,0,0,1, memw(32'h14), 32'h18, 1, 32'h18, 1);
    vt[8]  = mk(1,1,0,0,1, memw(32'h18), 32'h1C, 1, 32'h1C, 1);
    vt[9]  = mk(1,1,0,0,1, memw(32'h1C), 32'h20, 1, 32'h20, 1);
    // Flush at 0x20 to 0x100: bubble, one REDIR cycle, then fetch 0x100.
    vt[10] = mk(1,1,1,32'h100,1, 32'h0, 32'h0, 0, 32'h100, 0);
    vt[11] = mk(1,1,0,0,1,       32'h0, 32'h0, 0, 32'h100, 1);
    vt[12] = mk(1,1,0,0,1, memw(32'h100), 32'h104, 1, 32'h104, 1);
    // Flush with IfIdWrite=0 is ignored; ready+stall parks the word.
    vt[13] = mk(1,0,1,32'h200,1, memw(32'h100), 32'h104, 1, 32'h104, 0);
    vt[14] = mk(1,1,0,0,1, memw(32'h104), 32'h108, 1, 32'h108, 1);
    // Memory not ready for three cycles: bubbles, address stable.
    vt[15] = mk(1,1,0,0,0, 32'h0, 32'h0, 0, 32'h108, 1);
    vt[16] = mk(1,1,0,0,0, 32'h0, 32'h0, 0, 32'h108, 1);
    vt[17] = mk(1,1,0,0,0, 32'h0, 32'h0, 0, 32'h108, 1);
    vt[18] = mk(1,1,0,0,1, memw(32'h108), 32'h10C, 1, 32'h10C, 1);
    // Not ready and stalled: everything holds.
    vt[19] = mk(0,1,0,0,0, memw(32'h108), 32'h10C, 1, 32'h10C, 1);
    // HOLD then flush: buffer dropped, REDIR re-flush reloads PC.
    vt[20] = mk(0,1,0,0,1, memw(32'h108), 32'h10C, 1, 32'h10C, 0);
    vt[21] = mk(1,1,1,32'hFFFF_FFFC,1, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 0);
    vt[22] = mk(1,1,1,32'h300,1,       32'h0, 32'h0, 0, 32'h300, 0);
    vt[23] = mk(0,1,0,0,1,             32'h0, 32'h0, 0, 32'h300, 1);
    // Wrap-around fetch at 0xFFFF_FFFC.
    vt[24] = mk(1,1,1,32'hFFFF_FFFC,1, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 0);
    vt[25] = mk(1,1,0,0,1,             32'h0, 32'h0, 0, 32'hFFFF_FFFC, 1);
    vt[26] = mk(1,1,0,0,1, memw(32'hFFFF_FFFC), 32'h0, 1, 32'h0, 1);
    vt[27] = mk(1,1,0,0,1, memw(32'h0), 32'h4, 1, 32'h4, 1);
    // Misaligned redirect target is used verbatim.
    vt[28] = mk(1,1,1,32'h402,1, 32'h0, 32'h0, 0, 32'h402, 0);
    vt[29] = mk(1,1,0,0,1,       32'h0, 32'h0, 0, 32'h402, 1);
    vt[30] = mk(1,1,0,0,1, memw(32'h402), 32'h406, 1, 32'h406, 1);

    rst = 1'b0;
    drive(1, 1, 0, 32'h0, 1);
    #12;
    check_out("reset", 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("release", 32'h0, 32'h0, 0, 32'h0, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].pw, vt[i].iw, vt[i].fl, vt[i].rpc, vt[i].rdy);
      step();
      check_out($sformatf("vec%0d", i), vt[i].e_inst, vt[i].e_pc4,
                vt[i].e_valid, vt[i].e_addr, vt[i].e_req);
    end

    // Reset asserted mid-HOLD: outputs return immediately, parked word lost.
    drive(0, 1, 0, 32'h0, 1);
    step();
    check_out("enter_hold", memw(32'h402), 32'h406, 1, 32'h406, 0);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 32'h0, 1);
    step();
    check_out("after_rst", memw(32'h0), 32'h4, 1, 32'h4, 1);

    // Fresh reset, memory idle for three cycles, then one stalled cycle.
    @(negedge clk);
    rst = 1'b0;
    #3;
    rst = 1'b1;
    drive(1, 1, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("idle%0d", k), 32'h0, 32'h0, 0, 32'h0, 1);
    end
`ifdef FETCH_PERF_EN
    chk("perf.bubble3", bubble_cycles, 32'd3);
    chk("perf.stall0", stall_cycles, 32'd0);
`endif
    drive(0, 1, 0, 32'h0, 0);
    step();
    check_out("idle_stall", 32'h0, 32'h0, 0, 32'h0, 1);
`ifdef FETCH_PERF_EN
    chk("perf.stall1", stall_cycles, 32'd1);
    chk("perf.bubble_hold", bubble_cycles, 32'd3);
`endif
    drive(1, 1, 0, 32'h0, 1);
    step();
    check_out("resume", memw(32'h0), 32'h4, 1, 32'h4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
